video_pos_tracker: RTL and testbench

Parametrised successor to the pixel-position counter in the video pipeline.
- Delays the video stream (data/hsync/vsync/de) by a configurable number of pipeline stages.
- Produces hcount/vcount aligned with the delayed pixel, plus start-of-frame, end-of-line and end-of-frame strobes.
- Produces a per-pixel ROI window flag from frame-latched runtime coordinates.
- Sits directly after video input timing, ahead of filters and overlays that need pixel coordinates.

---
 rtl/video_pos_tracker.sv | 160 ++++++++++++++++
 tb/tb_video_pos_tracker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_pos_tracker.sv
// Pixel-position tracker: delays the video stream by DELAY stages and emits aligned hcount/vcount,
// sof/eol/eof strobes and an ROI flag. Define VIDEO_POS_MEASURE_EN to add line/frame measurement outputs.
module video_pos_tracker #(
  parameter int DW     = 24,
  parameter int IW     = 1920,
  parameter int IH     = 1080,
  parameter int CW     = 12,
  parameter int DELAY  = 1,
  parameter int VS_POL = 0
) (
  input  logic          pixelclk,
  input  logic          reset_n,
  input  logic [DW-1:0] i_data,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_de,
  input  logic [CW-1:0] roi_x0,
  input  logic [CW-1:0] roi_x1,
  input  logic [CW-1:0] roi_y0,
  input  logic [CW-1:0] roi_y1,
  output logic [DW-1:0] o_data,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [CW-1:0] o_hcount,
  output logic [CW-1:0] o_vcount,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_eof,
  output logic          o_roi
`ifdef VIDEO_POS_MEASURE_EN
  ,
  output logic [CW-1:0] o_line_width,
  output logic [CW-1:0] o_frame_lines,
  output logic          o_fmt_err
`endif
);

  localparam logic [CW-1:0] CMAX    = '1;
  localparam logic [CW-1:0] IH_LAST = CW'(IH - 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          hs;
    logic          vs;
    logic          de;
    logic          roi;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
  } stage_t;

  stage_t        pipe [DELAY];
  stage_t        stage_in;
  logic          vs_act_q;
  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] rx0, rx1, ry0, ry1;

  logic          vs_act, frame_start, de_rise, de_fall;
  logic [CW-1:0] h_next, v_next, v_pix;
  logic [DELAY:0] de_ext;

  // Counts are computed on the input side and travel down the pipe with their pixel.
  always_comb begin
    vs_act      = (VS_POL != 0) ? i_vsync : ~i_vsync;
    frame_start = vs_act & ~vs_act_q;
    de_rise     = i_de & ~pipe[0].de;
    de_fall     = ~i_de & pipe[0].de;

    h_next = h_cnt;
    if (de_rise)                    h_next = '0;
    else if (i_de && h_cnt != CMAX) h_next = h_cnt + 1'b1;

    v_pix  = frame_start ? '0 : v_cnt;
    v_next = v_cnt;
    if (frame_start)                   v_next = '0;
    else if (de_fall && v_cnt != CMAX) v_next = v_cnt + 1'b1;

    stage_in      = '0;
    stage_in.data = i_data;
    stage_in.hs   = i_hsync;
    stage_in.vs   = i_vsync;
    stage_in.de   = i_de;
    stage_in.h    = h_next;
    stage_in.v    = v_pix;
    stage_in.roi  = i_de && (rx0 <= h_next) && (h_next <= rx1) &&
                    (ry0 <= v_pix) && (v_pix <= ry1);
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_act_q <= 1'b0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      rx0      <= '0;
      rx1      <= '0;
      ry0      <= '0;
      ry1      <= '0;
      for (int k = 0; k < DELAY; k++) pipe[k] <= '0;
    end else begin
      vs_act_q <= vs_act;
      h_cnt    <= h_next;
      v_cnt    <= v_next;
      if (frame_start) begin
        rx0 <= roi_x0;
        rx1 <= roi_x1;
        ry0 <= roi_y0;
        ry1 <= roi_y1;
      end
      pipe[0] <= stage_in;
      for (int k = 1; k < DELAY; k++) pipe[k] <= pipe[k-1];
    end
  end

  // de of the output pixel's successor sits one stage earlier (the raw input when DELAY is 1).
  always_comb begin
    de_ext    = '0;
    de_ext[0] = i_de;
    for (int k = 0; k < DELAY; k++) de_ext[k+1] = pipe[k].de;
  end

  assign o_data   = pipe[DELAY-1].data;
  assign o_hsync  = pipe[DELAY-1].hs;
  assign o_vsync  = pipe[DELAY-1].vs;
  assign o_de     = pipe[DELAY-1].de;
  assign o_hcount = pipe[DELAY-1].h;
  assign o_vcount = pipe[DELAY-1].v;
  assign o_roi    = pipe[DELAY-1].roi;
  assign o_sof    = o_de && (o_hcount == '0) && (o_vcount == '0);
  assign o_eol    = de_ext[DELAY] & ~de_ext[DELAY-1];
  assign o_eof    = o_eol && (o_vcount == IH_LAST);

`ifdef VIDEO_POS_MEASURE_EN
  logic [CW-1:0] lw_q, fl_q, lw_next;
  logic          fe_q;

  always_comb begin
    lw_next = lw_q;
    if (de_fall) lw_next = (h_cnt == CMAX) ? CMAX : h_cnt + 1'b1;
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      lw_q <= '0;
      fl_q <= '0;
      fe_q <= 1'b0;
    end else begin
      lw_q <= lw_next;
      if (frame_start) begin
        fl_q <= v_cnt;
        fe_q <= (lw_next != CW'(IW)) || (v_cnt != CW'(IH));
      end
    end
  end

  assign o_line_width  = lw_q;
  assign o_frame_lines = fl_q;
  assign o_fmt_err     = fe_q;
`endif

endmodule

// File: tb/tb_video_pos_tracker.sv
// Randomized bench for video_pos_tracker: a frame/line-level model predicts every output pixel,
// a monitor compares the delayed stream, counts and strobes against it.
module tb_video_pos_tracker;
  localparam int DW = 24, IW = 8, IH = 4, CW = 4, DELAY = 2, VS_POL = 0;
  localparam int EW = DW + 2*CW + 4;
  localparam int HW = DW + 3;
  localparam logic VS_ON  = (VS_POL != 0);
  localparam logic VS_OFF = ~VS_ON;

  logic          pixelclk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] i_data;
  logic          i_hsync, i_vsync, i_de;
  logic [CW-1:0] roi_x0, roi_x1, roi_y0, roi_y1;
  logic [DW-1:0] o_data;
  logic          o_hsync, o_vsync, o_de;
  logic [CW-1:0] o_hcount, o_vcount;
  logic          o_sof, o_eol, o_eof, o_roi;

  video_pos_tracker #(.DW(DW), .IW(IW), .IH(IH), .CW(CW), .DELAY(DELAY), .VS_POL(VS_POL)) dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_data(i_data), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0),
    .roi_y1(roi_y1), .o_data(o_data), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_hcount(o_hcount), .o_vcount(o_vcount), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
    .o_roi(o_roi)
  );

  // ---------------- clock / reset / cycle history ----------------
  always #5 pixelclk = ~pixelclk;

  int          cyc = 0;
  logic [HW-1:0] hist_q[$];
  always @(posedge pixelclk) begin
    cyc++;
    hist_q.push_back(reset_n ? {i_vsync, i_hsync, i_de, i_data} : '0);
    if (hist_q.size() > 16) void'(hist_q.pop_front());
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            roi_seen, sof_seen, eof_seen;
  logic [CW-1:0] last_h;
  logic          have_last = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge pixelclk) begin
    if (reset_n) begin
      if (hist_q.size() >= DELAY)
        check("stream_delay",
              64'({o_vsync, o_hsync, o_de, o_data, (o_de ? 4'b0 : {o_sof, o_eol, o_eof, o_roi})}),
              64'({hist_q[hist_q.size()-DELAY], 4'b0}));
      if (o_de) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 64'(exp_q.size()), 64'(1));
        end else begin
          logic [EW-1:0] e;
          int            c;
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("pixel", 64'({o_data, o_hcount, o_vcount, o_sof, o_eol, o_eof, o_roi}), 64'(e));
          check("latency", 64'(cyc - c), 64'(DELAY));
          last_h    = e[4 + CW +: CW];
          have_last = 1'b1;
        end
        roi_seen += int'(o_roi);
        sof_seen += int'(o_sof);
        eof_seen += int'(o_eof);
      end else if (have_last) begin
        check("hcount_hold", 64'(o_hcount), 64'(last_h));
      end
    end
  end

  // ---------------- reference model state ----------------
  int            line_idx = 0;
  logic [CW-1:0] fx0 = '0, fx1 = '0, fy0 = '0, fy1 = '0;

  // ---------------- driver tasks ----------------
  task automatic set_in(logic de, logic [DW-1:0] data, logic hs, logic vs);
    @(posedge pixelclk);
    #1;
    i_de = de; i_data = data; i_hsync = hs; i_vsync = vs;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) set_in(1'b0, '0, 1'b0, VS_OFF);
  endtask

  task automatic check_all_zero(string name);
    check(name, 64'({o_data, o_hsync, o_vsync, o_de, o_hcount, o_vcount, o_sof, o_eol, o_eof, o_roi}), 64'(0));
  endtask

  task automatic vsync_pulse();
    idle(2);
    set_in(1'b0, '0, 1'b0, VS_ON);
    fx0 = roi_x0; fx1 = roi_x1; fy0 = roi_y0; fy1 = roi_y1;
    line_idx = 0;
    set_in(1'b0, '0, 1'b0, VS_ON);
    idle(2);
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    exp_q.delete();
    exp_cyc_q.delete();
    hist_q.delete();
    have_last = 1'b0;
    line_idx  = 0;
    i_de = 1'b0; i_data = '0; i_hsync = 1'b0; i_vsync = VS_OFF;
    repeat (3) @(posedge pixelclk);
    #1;
    check_all_zero("reset_hold");
    reset_n = 1'b1;
  endtask

  // One active line of 'width' pixels; rst_pix >= 0 aborts with an async reset on that pixel.
  task automatic drive_line(int width, int rst_pix);
    for (int p = 0; p < width; p++) begin
      logic [DW-1:0] d;
      int            h, v;
      logic          sof, eol, eof, roi;
      d = DW'($urandom);
      set_in(1'b1, d, 1'b0, VS_OFF);
      if (p == rst_pix) begin
        async_reset();
        return;
      end
      h   = (p > 15) ? 15 : p;
      v   = (line_idx > 15) ? 15 : line_idx;
      sof = (h == 0) && (v == 0);
      eol = (p == width - 1);
      eof = eol && (v == IH - 1);
      roi = (h >= fx0) && (h <= fx1) && (v >= fy0) && (v <= fy1);
      exp_q.push_back({d, CW'(h), CW'(v), sof, eol, eof, roi});
      exp_cyc_q.push_back(cyc);
    end
    line_idx++;
    set_in(1'b0, '0, 1'b1, VS_OFF);
    idle($urandom_range(1, 3));
  endtask

  task automatic frame(int lines, int width);
    vsync_pulse();
    roi_seen = 0; sof_seen = 0; eof_seen = 0;
    for (int l = 0; l < lines; l++) drive_line(width, -1);
    idle(DELAY + 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    i_de = 1'b0; i_data = '0; i_hsync = 1'b0; i_vsync = VS_OFF;
    roi_x0 = '0; roi_x1 = '0; roi_y0 = '0; roi_y1 = '0;
    repeat (3) @(posedge pixelclk);
    #1;
    check_all_zero("reset_state");
    reset_n = 1'b1;
    idle(4);

    // Nominal 4x8 frame; ROI written mid-frame must not apply yet.
    vsync_pulse();
    roi_seen = 0; sof_seen = 0; eof_seen = 0;
    for (int l = 0; l < 4; l++) begin
      if (l == 2) begin roi_x0 = 4'd2; roi_x1 = 4'd5; roi_y0 = 4'd1; roi_y1 = 4'd2; end
      drive_line(8, -1);
    end
    idle(DELAY + 3);
    check("sof_count_f0", 64'(sof_seen), 64'(1));
    check("eof_count_f0", 64'(eof_seen), 64'(1));
    check("roi_count_f0", 64'(roi_seen), 64'(1));

    frame(4, 8);
    check("roi_count_f1", 64'(roi_seen), 64'(8));

    roi_x0 = 4'd6; roi_x1 = 4'd3; roi_y0 = 4'd0; roi_y1 = 4'd3;
    frame(4, 10);
    check("roi_count_inverted", 64'(roi_seen), 64'(0));
    check("eof_count_wide", 64'(eof_seen), 64'(1));

    // Saturating 20-pixel line, a 1-pixel de glitch, then random widths.
    roi_x0 = 4'd14; roi_x1 = 4'd15; roi_y0 = 4'd0; roi_y1 = 4'd0;
    vsync_pulse();
    drive_line(20, -1);
    drive_line(1, -1);
    for (int l = 0; l < 3; l++) drive_line($urandom_range(1, 20), -1);
    idle(DELAY + 3);

    // Reset at line 2 pixel 3, then a clean frame must restart at (0,0) with sof.
    vsync_pulse();
    drive_line(8, -1);
    drive_line(8, -1);
    drive_line(8, 3);
    idle(3);
    frame(4, 8);
    check("sof_after_reset", 64'(sof_seen), 64'(1));

    for (int f = 0; f < 4; f++) begin
      roi_x0 = CW'($urandom_range(0, 15)); roi_x1 = CW'($urandom_range(0, 15));
      roi_y0 = CW'($urandom_range(0, 5));  roi_y1 = CW'($urandom_range(0, 5));
      vsync_pulse();
      for (int l = $urandom_range(1, 6); l > 0; l--) drive_line($urandom_range(1, 20), -1);
      idle(DELAY + 3);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
